// File: rtl/mem_tester_pkg.sv
// Shared types and helpers for the on-chip RAM tester: FSM encoding, error counter width, test pattern.
package mem_tester_pkg;

  localparam int ERR_CNT_W = 16;
  localparam int PAT_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Word i of the test pattern; callers truncate to their data width.
  function automatic logic [PAT_W-1:0] pattern_word(input logic [PAT_W-1:0] seed,
                                                    input logic [PAT_W-1:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/onchip_mem_tester_if.sv
// Avalon-MM bus between the tester (master) and a single-port on-chip RAM (slave, fixed read latency).
interface onchip_mem_tester_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_clken;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
    output avm_readdata
  );
endinterface

// File: rtl/mem_tester_rd_pipe.sv
// Delays {valid, expected, address} by READ_LATENCY to meet returning read data; counts mismatches.
// Latency READ_LATENCY cycles; no backpressure, one compare per cycle.
module mem_tester_rd_pipe
  import mem_tester_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 issue_vld_i,
  input  logic [DATA_W-1:0]    issue_dat_i,
  input  logic [ADDR_W-1:0]    issue_addr_i,
  input  logic [DATA_W-1:0]    rd_dat_i,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [ADDR_W-1:0]    first_err_addr_o
);
  localparam int LAST = READ_LATENCY - 1;

  logic                 vld_q  [READ_LATENCY];
  logic [DATA_W-1:0]    exp_q  [READ_LATENCY];
  logic [ADDR_W-1:0]    addr_q [READ_LATENCY];
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]    first_q, first_d;
  logic                 mismatch;

  assign mismatch = vld_q[LAST] && (rd_dat_i != exp_q[LAST]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        vld_q[s]  <= 1'b0;
        exp_q[s]  <= '0;
        addr_q[s] <= '0;
      end
    end else begin
      vld_q[0]  <= issue_vld_i;
      exp_q[0]  <= issue_dat_i;
      addr_q[0] <= issue_addr_i;
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_q[s]  <= vld_q[s-1];
        exp_q[s]  <= exp_q[s-1];
        addr_q[s] <= addr_q[s-1];
      end
    end
  end

  // Counter saturates; a non-zero count also marks that the first address is already held.
  always_comb begin
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    if (clear_i) begin
      err_cnt_d = '0;
      first_d   = '0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      if (err_cnt_q == '0) first_d = addr_q[LAST];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_q;
endmodule

// File: rtl/onchip_mem_tester.sv
// Avalon-MM RAM self-test master: writes seed+i over a wrapping window, reads back, counts mismatches.
// One access per cycle, done 2*length+READ_LATENCY+1 cycles after start; slave never stalls, no backpressure.
module onchip_mem_tester
  import mem_tester_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  onchip_mem_tester_if.master  avm
);
  localparam logic [ADDR_W:0] IDX_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DRAIN_LAST = (ADDR_W+1)'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic              done_q, done_d;
  logic              start_acc, last_idx, rd_issue;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign last_idx  = (idx_q == len_q - IDX_ONE);
  assign rd_issue  = (state_q == ST_READ);
  assign cur_addr  = base_q + idx_q[ADDR_W-1:0];
  assign cur_data  = DATA_W'(pattern_word(PAT_W'(seed_q), PAT_W'(idx_q)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (start_acc) begin
        base_q <= base_addr;
        len_q  <= length;
        seed_q <= seed;
      end
    end
  end

  // idx_q counts words in WRITE/READ and drain cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (length == '0) ? ST_DONE : ST_WRITE;
          idx_d   = '0;
        end
      end
      ST_WRITE: begin
        if (last_idx) begin
          state_d = ST_READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_READ: begin
        if (last_idx) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_DRAIN: begin
        if (idx_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE) ? 1'b1 : (start_acc ? 1'b0 : done_q);
  end

  always_comb begin
    busy               = 1'b0;
    avm.avm_chipselect = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_address    = '0;
    avm.avm_writedata  = '0;
    unique case (state_q)
      ST_WRITE: begin
        busy               = 1'b1;
        avm.avm_chipselect = 1'b1;
        avm.avm_write      = 1'b1;
        avm.avm_address    = cur_addr;
        avm.avm_writedata  = cur_data;
      end
      ST_READ: begin
        busy               = 1'b1;
        avm.avm_chipselect = 1'b1;
        avm.avm_address    = cur_addr;
      end
      ST_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  assign avm.avm_byteenable = '1;
  assign avm.avm_clken      = 1'b1;

  mem_tester_rd_pipe #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear_i          (start_acc),
    .issue_vld_i      (rd_issue),
    .issue_dat_i      (cur_data),
    .issue_addr_i     (cur_addr),
    .rd_dat_i         (avm.avm_readdata),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

  assign done = done_q;
  assign pass = done_q && (err_count == '0);
endmodule

// File: tb/tb_onchip_mem_tester.sv
// Bench for onchip_mem_tester: READ_LATENCY=1 and READ_LATENCY=3 instances, each on a behavioural RAM.
module tb_onchip_mem_tester;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BOUND = 4000;

  logic clk = 1'b0;
  logic reset_n;
  logic            start_s [2];
  logic [AW-1:0]   base_s  [2];
  logic [AW:0]     len_s   [2];
  logic [DW-1:0]   seed_s  [2];
  logic            busy_s  [2];
  logic            done_s  [2];
  logic            pass_s  [2];
  logic [15:0]     errc_s  [2];
  logic [AW-1:0]   fea_s   [2];
  logic            cs_s    [2];
  logic            wr_s    [2];
  logic            clken_s [2];
  logic [AW-1:0]   addr_s  [2];
  logic [DW-1:0]   wd_s    [2];
  logic [DW/8-1:0] be_s    [2];
  bit              corrupt [1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int RL = (k == 0) ? 1 : 3;
    onchip_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) avm_if ();
    onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
      .clk(clk), .reset_n(reset_n), .start(start_s[k]), .base_addr(base_s[k]),
      .length(len_s[k]), .seed(seed_s[k]), .busy(busy_s[k]), .done(done_s[k]),
      .pass(pass_s[k]), .err_count(errc_s[k]), .first_err_addr(fea_s[k]), .avm(avm_if)
    );

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge clk) begin
      if (avm_if.avm_clken && avm_if.avm_chipselect && avm_if.avm_write) begin
        for (int b = 0; b < DW/8; b++)
          if (avm_if.avm_byteenable[b])
            mem[avm_if.avm_address][8*b +: 8] <= avm_if.avm_writedata[8*b +: 8];
      end
      if (avm_if.avm_chipselect && !avm_if.avm_write)
        rd_pipe[0] <= mem[avm_if.avm_address] ^ (corrupt[avm_if.avm_address] ? 32'hDEAD_BEEF : 32'h0);
      else
        rd_pipe[0] <= '0;
      for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    assign avm_if.avm_readdata = rd_pipe[RL-1];
    assign cs_s[k]    = avm_if.avm_chipselect;
    assign wr_s[k]    = avm_if.avm_write;
    assign addr_s[k]  = avm_if.avm_address;
    assign wd_s[k]    = avm_if.avm_writedata;
    assign be_s[k]    = avm_if.avm_byteenable;
    assign clken_s[k] = avm_if.avm_clken;
  end

  function automatic logic [DW-1:0] mem_rd(input int k, input logic [AW-1:0] a);
    if (k == 0) return g_inst[0].mem[a];
    return g_inst[1].mem[a];
  endfunction

  // Runs one test on instance k and checks it against the window/pattern model.
  task automatic run_test(input int k, input logic [AW-1:0] base, input logic [AW:0] len,
                          input logic [DW-1:0] seed, input bit poke, input string name);
    int rl, exp_done, exp_err, c, bus_bad, busy_bad, mem_bad;
    logic [AW-1:0] exp_fea, a, e_addr;
    logic [DW-1:0] e_wd;
    logic e_cs, e_wr, chk_wd;
    bit seen;
    rl       = (k == 0) ? 1 : 3;
    exp_done = (len == 0) ? 1 : 2 * int'(len) + rl + 1;
    exp_err  = 0;
    exp_fea  = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = base + AW'(i);
      if (corrupt[a]) begin
        if (exp_err == 0) exp_fea = a;
        exp_err++;
      end
    end
    bus_bad = 0; busy_bad = 0; mem_bad = 0; c = 0; seen = 0;

    @(posedge clk); #1;
    start_s[k] = 1'b1; base_s[k] = base; len_s[k] = len; seed_s[k] = seed;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    while (!seen && c < BOUND) begin
      @(negedge clk);
      c++;
      e_cs = 0; e_wr = 0; e_addr = '0; e_wd = '0; chk_wd = 1;
      if (c <= int'(len)) begin
        e_cs = 1; e_wr = 1; e_addr = base + AW'(c - 1); e_wd = seed + DW'(c - 1);
      end else if (c <= 2 * int'(len)) begin
        e_cs = 1; e_addr = base + AW'(c - int'(len) - 1); chk_wd = 0;
      end
      if (cs_s[k] !== e_cs || wr_s[k] !== e_wr || addr_s[k] !== e_addr ||
          (chk_wd && wd_s[k] !== e_wd) || be_s[k] !== 4'hF || clken_s[k] !== 1'b1)
        bus_bad++;
      if (busy_s[k] !== (c < exp_done)) busy_bad++;
      if (done_s[k] === 1'b1) seen = 1;
      base_s[k] = AW'($urandom);
      len_s[k]  = (AW+1)'($urandom);
      seed_s[k] = $urandom;
      start_s[k] = poke && (c == 5);
    end
    start_s[k] = 1'b0;

    checks++;
    if (!seen || c != exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d (seen=%0d) expected %0d", name, c, seen, exp_done);
    end
    checks++;
    if (pass_s[k] !== (exp_err == 0)) begin
      errors++;
      $display("FAIL %s pass: got %b expected %b", name, pass_s[k], exp_err == 0);
    end
    checks++;
    if (errc_s[k] !== 16'(exp_err)) begin
      errors++;
      $display("FAIL %s err_count: got %0d expected %0d", name, errc_s[k], exp_err);
    end
    checks++;
    if (fea_s[k] !== exp_fea) begin
      errors++;
      $display("FAIL %s first_err_addr: got %h expected %h", name, fea_s[k], exp_fea);
    end
    checks++;
    if (bus_bad != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL %s bus_sequence: bad bus cycles %0d bad busy cycles %0d, expected 0 and 0", name, bus_bad, busy_bad);
    end
    if (len != 0) begin
      for (int i = 0; i < int'(len); i++)
        if (mem_rd(k, base + AW'(i)) !== seed + DW'(i)) mem_bad++;
      checks++;
      if (mem_bad != 0) begin
        errors++;
        $display("FAIL %s ram_contents: %0d words wrong, expected 0", name, mem_bad);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy_s[k] !== 0 || done_s[k] !== 0 || pass_s[k] !== 0 || errc_s[k] !== 0 || fea_s[k] !== 0) begin
        errors++;
        $display("FAIL reset_status[%0d]: busy=%b done=%b pass=%b err=%0d fea=%h, expected all 0",
                 k, busy_s[k], done_s[k], pass_s[k], errc_s[k], fea_s[k]);
      end
      checks++;
      if (cs_s[k] !== 0 || wr_s[k] !== 0 || addr_s[k] !== 0 || wd_s[k] !== 0 ||
          be_s[k] !== 4'hF || clken_s[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_bus[%0d]: cs=%b wr=%b addr=%h wd=%h be=%h clken=%b, expected 0 0 0 0 f 1",
                 k, cs_s[k], wr_s[k], addr_s[k], wd_s[k], be_s[k], clken_s[k]);
      end
    end
  endtask

  task automatic test_basic();
    run_test(0, 10'h000, 11'd4, 32'h0000_1000, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_test(0, 10'h3FE, 11'd4, 32'h0, 1'b0, "wrap");
  endtask

  task automatic test_corrupt();
    corrupt[5] = 1; corrupt[7] = 1;
    run_test(0, 10'h000, 11'd8, $urandom, 1'b0, "corrupt");
    checks++;
    if (errc_s[0] !== 16'd2 || fea_s[0] !== 10'd5 || pass_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_summary: err=%0d fea=%h pass=%b, expected 2 005 0", errc_s[0], fea_s[0], pass_s[0]);
    end
    corrupt[5] = 0; corrupt[7] = 0;
  endtask

  task automatic test_zero_len();
    run_test(0, AW'($urandom), 11'd0, $urandom, 1'b0, "zero_len");
  endtask

  task automatic test_reset_mid_read();
    logic [DW-1:0] sd;
    sd = $urandom;
    @(posedge clk); #1;
    start_s[0] = 1; base_s[0] = 10'h040; len_s[0] = 11'd8; seed_s[0] = sd;
    @(posedge clk); #1;
    start_s[0] = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_s[0] !== 1'b1 || cs_s[0] !== 1'b1 || wr_s[0] !== 1'b0 || addr_s[0] !== 10'h041) begin
      errors++;
      $display("FAIL mid_read_state: busy=%b cs=%b wr=%b addr=%h, expected 1 1 0 041", busy_s[0], cs_s[0], wr_s[0], addr_s[0]);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s[0] !== 0 || done_s[0] !== 0 || pass_s[0] !== 0 || errc_s[0] !== 0 || fea_s[0] !== 0 ||
        cs_s[0] !== 0 || wr_s[0] !== 0 || addr_s[0] !== 0 || wd_s[0] !== 0) begin
      errors++;
      $display("FAIL mid_read_reset: busy=%b done=%b pass=%b cs=%b wr=%b addr=%h, expected all 0",
               busy_s[0], done_s[0], pass_s[0], cs_s[0], wr_s[0], addr_s[0]);
    end
    reset_n = 1'b1;
    run_test(0, 10'h040, 11'd2, sd, 1'b0, "post_reset");
  endtask

  task automatic test_start_in_done();
    run_test(0, 10'h014, 11'd3, $urandom, 1'b0, "pre_done_start");
    start_s[0] = 1; base_s[0] = 10'h100; len_s[0] = 11'd2;
    @(posedge clk); #1;
    start_s[0] = 0;
    @(negedge clk);
    checks++;
    if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || cs_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: done=%b busy=%b cs=%b, expected 1 0 0", done_s[0], busy_s[0], cs_s[0]);
    end
  endtask

  task automatic test_rl3_poke();
    run_test(1, 10'h000, 11'd16, $urandom, 1'b1, "rl3_poke");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int k;
      logic [AW-1:0] b;
      logic [AW:0] l;
      k = int'($urandom_range(0, 1));
      b = AW'($urandom);
      l = (AW+1)'($urandom_range(1, 48));
      for (int j = 0; j < 2; j++)
        if ($urandom_range(0, 1) == 1) corrupt[b + AW'($urandom_range(0, int'(l) - 1))] = 1;
      run_test(k, b, l, $urandom, 1'b0, $sformatf("random%0d", t));
      for (int i = 0; i < 1024; i++) corrupt[i] = 0;
    end
  endtask

  task automatic test_full_window();
    run_test(0, AW'($urandom), 11'd1024, $urandom, 1'b0, "full_window");
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; base_s[k] = '0; len_s[k] = '0; seed_s[k] = '0;
    end
    for (int i = 0; i < 1024; i++) corrupt[i] = 0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_basic();
    test_wrap();
    test_corrupt();
    test_zero_len();
    test_reset_mid_read();
    test_start_in_done();
    test_rl3_poke();
    test_random();
    test_full_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
